spi_master_exe_ctrl: RTL
========================

// Module: spi_master_exe_ctrl
// PURPOSE
//  SPI master (initiator) for the 4-bit SPI execution unit slave. Takes a BITS-wide command frame
//  ({argA,argB,oper,res,flags}) from the host, generates SCLK/MOSI/CS and captures the MISO frame.
//  Sits between host logic on the system clock and the exe-unit slave port. Frame N's response
//  carries the slave's result for frame N-1, so the host decodes results one frame late.
// PARAMETERS
//  BITS      20  frame length in bits, MSB first
//  CLK_DIV   2   system clocks per SCLK half-period (>=1)
//  CS_ADDR   3   3-bit code driven on o_cs while a frame is active
//  CS_IDLE   0   3-bit code driven on o_cs when no frame is active
//  TAIL_CLKS 2   extra SCLK pulses after CS release (slave compute/load cycles)
// PORTS
//  i_clk_p    in   1     system clock, rising edge
//  i_rst_n    in   1     asynchronous reset, active low
//  i_start    in   1     start request; accepted only when o_busy==0
//  i_tx_data  in   BITS  frame to send; latched on accepted start
//  o_busy     out  1     transaction in progress
//  o_done     out  1     one-cycle pulse: frame finished, o_rx_data valid
//  o_rx_data  out  BITS  last received MISO frame; held until next o_done
//  o_sclk     out  1     SPI clock, idle low (CPOL=0)
//  o_mosi     out  1     SPI data to slave
//  i_miso     in   1     SPI data from slave
//  o_cs       out  3     slave select code
// BEHAVIOUR
//  Reset (async, i_rst_n=0): state IDLE; o_sclk=0, o_mosi=0, o_cs=CS_IDLE, o_busy=0,
//   o_done=0, o_rx_data=0, counters and tx/rx shift registers 0. Reset mid-frame aborts with no o_done.
//  All outputs are registered; o_sclk only changes on i_clk_p edges where the divider hits CLK_DIV-1.
//  States: IDLE -> LEAD -> SHIFT -> TRAIL -> FLUSH -> IDLE.
//  IDLE: o_busy=0. On i_start: latch i_tx_data, o_cs<=CS_ADDR, o_mosi<=i_tx_data[BITS-1],
//   o_busy<=1, go LEAD. i_start while o_busy=1 is ignored (no queue).
//  LEAD: CLK_DIV cycles, o_sclk low (CS setup).
//  SHIFT: BITS SCLK periods, high then low, each half CLK_DIV cycles.
//   On the clock edge that drives o_sclk 0->1, shift i_miso into rx LSB.
//   On the edge that drives o_sclk 1->0, present next tx bit on o_mosi (none after the last bit).
//  TRAIL: CLK_DIV cycles o_sclk low; then o_cs<=CS_IDLE, o_mosi<=0.
//  FLUSH: TAIL_CLKS full SCLK periods with o_cs=CS_IDLE, o_mosi=0; i_miso ignored.
//   TAIL_CLKS=0 skips FLUSH.
//  Completion: o_rx_data<=rx shift reg, o_done=1 for one cycle, o_busy=0 in that same cycle.
//   Start is accepted in the o_done cycle, so frames can run back to back.
//  Latency: start sampled at edge k -> o_done high at edge k+N, with
//   N = CLK_DIV*(2 + 2*BITS + 2*TAIL_CLKS) (defaults: N=92).
//   o_busy=1 for edges k+1..k+N-1.
//  Counters: divider width $clog2(CLK_DIV); bit counter width $clog2(BITS+TAIL_CLKS)+1.
//   No wrap-around within a frame.
//  i_tx_data changes while busy have no effect. o_rx_data is stable except in the o_done cycle.
// TESTING
//  1 Reset: assert i_rst_n=0 mid-SHIFT -> next cycle o_sclk=0, o_cs=0, o_busy=0, no o_done;
//    after release, a new start runs a full frame.
//  2 Loopback i_miso=o_mosi, tx=20'hA5C3F -> o_rx_data=20'hA5C3F, o_done at start+92 cycles.
//  3 Waveform check, tx=20'h80001 -> 20 SCLK rises with CS=3, then 2 rises with CS=0;
//    MOSI=1 only at bits 19 and 0; MOSI stable across every rise.
//  4 Back-to-back: start held high -> second frame's LEAD begins the cycle after o_done;
//    start pulses while busy ignored (exactly one o_done per accepted start).
//  5 Slave model (exe unit, ADD): frame {A=3,B=4,op=ADD,0,0} then any frame ->
//    second o_rx_data[7:4]=7 with flags as the ALU defines.
//  6 CLK_DIV=1, TAIL_CLKS=0, BITS=8: tx=8'h5A loopback -> rx=8'h5A, o_done at start+18.

Source files
------------

// File: rtl/spi_master_exe_ctrl.sv
// SPI master for the 4-bit execution-unit slave.
// Sends one command frame MSB first (CPOL=0) and captures the slave's reply in
// the same frame. Extra SCLK pulses follow with CS released so the slave can
// compute and load its next response.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no frame; o_cs=CS_IDLE; a start request is accepted here
// S_LEAD  | CS asserted, SCLK low for one half period (CS setup)
// S_SHIFT | BITS SCLK periods; sample MISO on rise, advance MOSI on fall
// S_TRAIL | SCLK low for one half period, then release CS
// S_FLUSH | TAIL_CLKS SCLK periods with CS released, MISO ignored
module spi_master_exe_ctrl #(
  parameter int unsigned BITS      = 20,
  parameter int unsigned CLK_DIV   = 2,
  parameter logic [2:0]  CS_ADDR   = 3'd3,
  parameter logic [2:0]  CS_IDLE   = 3'd0,
  parameter int unsigned TAIL_CLKS = 2
) (
  input  logic            i_clk_p,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [BITS-1:0] i_tx_data,
  output logic            o_busy,
  output logic            o_done,
  output logic [BITS-1:0] o_rx_data,
  output logic            o_sclk,
  output logic            o_mosi,
  input  logic            i_miso,
  output logic [2:0]      o_cs
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(BITS + TAIL_CLKS) + 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BITS - 1);
  // Unused when TAIL_CLKS is 0 because FLUSH is never entered.
  localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'((TAIL_CLKS > 0) ? TAIL_CLKS - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_SHIFT,
    S_TRAIL,
    S_FLUSH
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] bit_cnt;
  // MSB goes out directly at start, so only the remaining BITS-1 bits are held.
  logic [BITS-2:0]  tx_sh;
  logic [BITS-1:0]  rx_sh;
  logic             tick;

  // Half-period boundary: every SCLK edge and every phase change happens here.
  assign tick = (div_cnt == DIV_LAST);

  // Frame sequencer with all outputs registered.
  always_ff @(posedge i_clk_p or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_rx_data <= '0;
      o_sclk    <= 1'b0;
      o_mosi    <= 1'b0;
      o_cs      <= CS_IDLE;
    end else begin
      o_done <= 1'b0;
      if (state != S_IDLE) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (i_start) begin
            tx_sh   <= i_tx_data[BITS-2:0];
            rx_sh   <= '0;
            o_mosi  <= i_tx_data[BITS-1];
            o_cs    <= CS_ADDR;
            o_busy  <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
            state   <= S_LEAD;
          end
        end
        S_LEAD: begin
          if (tick) begin
            o_sclk <= 1'b1;
            rx_sh  <= {rx_sh[BITS-2:0], i_miso};
            state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (tick) begin
            if (o_sclk) begin
              o_sclk <= 1'b0;
              if (bit_cnt != BIT_LAST) begin
                o_mosi <= tx_sh[BITS-2];
                tx_sh  <= tx_sh << 1;
              end
            end else if (bit_cnt == BIT_LAST) begin
              // Last low half has elapsed; MOSI keeps bit 0 into TRAIL.
              state <= S_TRAIL;
            end else begin
              o_sclk  <= 1'b1;
              rx_sh   <= {rx_sh[BITS-2:0], i_miso};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        S_TRAIL: begin
          if (tick) begin
            o_cs    <= CS_IDLE;
            o_mosi  <= 1'b0;
            bit_cnt <= '0;
            if (TAIL_CLKS == 0) begin
              o_rx_data <= rx_sh;
              o_done    <= 1'b1;
              o_busy    <= 1'b0;
              state     <= S_IDLE;
            end else begin
              state <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          // Each tail pulse is a low half then a high half, so SCLK ends low.
          if (tick) begin
            if (!o_sclk) begin
              o_sclk <= 1'b1;
            end else begin
              o_sclk <= 1'b0;
              if (bit_cnt == TAIL_LAST) begin
                o_rx_data <= rx_sh;
                o_done    <= 1'b1;
                o_busy    <= 1'b0;
                state     <= S_IDLE;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
